// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - pipelined instruction fetch with outstanding-request tracking and ibuf
module if_prefetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_allowin,
    input  logic        exec_flush,
    input  logic [31:0] exec_pc,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    input  logic        br_taken_exe,
    input  logic [31:0] br_target_exe,
    input  logic        br_taken_id,
    input  logic [31:0] br_target_id,
    output logic        if_to_id_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_exc_rf,
    output logic        if_valid_rf
);

    localparam int CW  = $clog2(IBUF_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int IW  = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CW:0]   DEPTH_W = CW1'(IBUF_DEPTH);
    localparam logic [CW-1:0] MAXO_W  = CW'(MAX_OUTSTANDING);
    localparam logic [IW-1:0] ILAST   = IW'(IBUF_DEPTH - 1);
    localparam logic [PW-1:0] PLAST   = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   fetch_pc;
    logic          halt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic [31:0]   pend_pc [MAX_OUTSTANDING];
    logic [PW-1:0] pend_wptr;
    logic [PW-1:0] pend_rptr;

    logic [31:0]   ibuf_pc   [IBUF_DEPTH];
    logic [31:0]   ibuf_inst [IBUF_DEPTH];
    logic          ibuf_exc  [IBUF_DEPTH];
    logic [IW-1:0] ibuf_wptr;
    logic [IW-1:0] ibuf_rptr;
    logic [CW-1:0] ibuf_count;

    logic          redirect;
    logic [31:0]   redirect_target;
    logic          aligned;
    logic [CW:0]   credit_used;
    logic          slot_free;
    logic          fire;
    logic          resp_valid;
    logic          resp_keep;
    logic          adef_push;
    logic          ibuf_push;
    logic          ibuf_pop;
    logic [31:0]   push_pc;
    logic [31:0]   push_inst;
    logic          push_exc;

    function automatic logic [IW-1:0] ibuf_next(input logic [IW-1:0] p);
        return (p == ILAST) ? '0 : p + IW'(1);
    endfunction

    function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + PW'(1);
    endfunction

    assign redirect = exec_flush | ertn_flush | br_taken_exe | br_taken_id;

    always_comb begin
        redirect_target = br_target_id;
        if (exec_flush) begin
            redirect_target = exec_pc;
        end else if (ertn_flush) begin
            redirect_target = ertn_pc;
        end else if (br_taken_exe) begin
            redirect_target = br_target_exe;
        end
    end

    // Every request in flight already owns an ibuf slot, so the buffer can never overflow.
    assign aligned     = (fetch_pc[1:0] == 2'b00);
    assign credit_used = {1'b0, outstanding} + {1'b0, ibuf_count};
    assign slot_free   = (credit_used < DEPTH_W);

    assign inst_sram_req = ~resetn & ~halt & ~redirect & aligned
                         & (outstanding < MAXO_W) & slot_free;
    assign fire          = inst_sram_req & inst_sram_addr_ok;

    assign resp_valid = inst_sram_data_ok & (outstanding != '0);
    assign resp_keep  = resp_valid & ~redirect & (discard == '0);
    assign adef_push  = ~resetn & ~halt & ~redirect & ~aligned & slot_free & ~resp_keep;
    assign ibuf_push  = resp_keep | adef_push;
    assign ibuf_pop   = if_to_id_valid & id_allowin & ~redirect;

    assign push_pc   = resp_keep ? pend_pc[pend_rptr] : fetch_pc;
    assign push_inst = resp_keep ? inst_sram_rdata : 32'd0;
    assign push_exc  = ~resp_keep;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            fetch_pc    <= RESET_PC;
            halt        <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            pend_wptr   <= '0;
            pend_rptr   <= '0;
            ibuf_wptr   <= '0;
            ibuf_rptr   <= '0;
            ibuf_count  <= '0;
        end else begin
            if (redirect) begin
                fetch_pc   <= redirect_target;
                halt       <= 1'b0;
                discard    <= outstanding - CW'(resp_valid);
                ibuf_wptr  <= '0;
                ibuf_rptr  <= '0;
                ibuf_count <= '0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (adef_push) begin
                    halt <= 1'b1;
                end
                if (resp_valid && discard != '0) begin
                    discard <= discard - CW'(1);
                end
                if (ibuf_push) begin
                    ibuf_wptr <= ibuf_next(ibuf_wptr);
                end
                if (ibuf_pop) begin
                    ibuf_rptr <= ibuf_next(ibuf_rptr);
                end
                ibuf_count <= ibuf_count + CW'(ibuf_push) - CW'(ibuf_pop);
            end
            // Responses are owed whether or not we redirected, so the pending FIFO never flushes.
            outstanding <= outstanding + CW'(fire) - CW'(resp_valid);
            if (fire) begin
                pend_wptr <= pend_next(pend_wptr);
            end
            if (resp_valid) begin
                pend_rptr <= pend_next(pend_rptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            pend_pc[pend_wptr] <= fetch_pc;
        end
        if (ibuf_push) begin
            ibuf_pc[ibuf_wptr]   <= push_pc;
            ibuf_inst[ibuf_wptr] <= push_inst;
            ibuf_exc[ibuf_wptr]  <= push_exc;
        end
    end

    assign if_to_id_valid = (ibuf_count != '0);
    assign if_valid_rf    = if_to_id_valid;
    assign if_pc          = if_to_id_valid ? ibuf_pc[ibuf_rptr]   : 32'd0;
    assign if_inst        = if_to_id_valid ? ibuf_inst[ibuf_rptr] : 32'd0;
    assign if_exc_rf      = if_to_id_valid ? ibuf_exc[ibuf_rptr]  : 1'b0;

    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - randomized and directed checks of if_prefetch_stage against a queue model
module tb_if_prefetch_stage;

    localparam logic [31:0] RPC   = 32'h1c000000;
    localparam int          MAXO  = 2;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic        id_allowin = 1'b0;
    logic        exec_flush = 1'b0, ertn_flush = 1'b0, br_taken_exe = 1'b0, br_taken_id = 1'b0;
    logic [31:0] exec_pc = 32'd0, ertn_pc = 32'd0, br_target_exe = 32'd0, br_target_id = 32'd0;
    logic        if_to_id_valid, if_exc_rf, if_valid_rf;
    logic [31:0] if_inst, if_pc;

    if_prefetch_stage #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .id_allowin(id_allowin),
        .exec_flush(exec_flush), .exec_pc(exec_pc), .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
        .br_taken_exe(br_taken_exe), .br_target_exe(br_target_exe),
        .br_taken_id(br_taken_id), .br_target_id(br_target_id),
        .if_to_id_valid(if_to_id_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_exc_rf(if_exc_rf), .if_valid_rf(if_valid_rf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } ent_t;

    logic [31:0] m_fpc;
    bit          m_halt;
    int          m_discard;
    logic [31:0] m_pend[$];
    ent_t        m_ibuf[$];
    logic [31:0] slave_q[$];
    int          resp_mode;

    logic        s_req, s_valid, s_exc;
    logic [31:0] s_addr, s_pc, s_inst;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc = RPC;
        m_halt = 0;
        m_discard = 0;
        m_pend.delete();
        m_ibuf.delete();
        slave_q.delete();
    endtask

    task automatic clear_redirects();
        exec_flush = 0; ertn_flush = 0; br_taken_exe = 0; br_taken_id = 0;
    endtask

    // One clock: compare at negedge against the model, advance model and bus slave, drive data_ok.
    task automatic cycle();
        logic        redirect, m_req, dok, misal;
        logic [31:0] tgt;
        int          outs;
        ent_t        e;
        @(negedge clk);
        s_req = inst_sram_req; s_addr = inst_sram_addr; s_valid = if_to_id_valid;
        s_pc = if_pc; s_inst = if_inst; s_exc = if_exc_rf;
        if (resetn) begin
            chk("rst_req", s_req, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_pc", s_pc, 0);
            chk("rst_inst", s_inst, 0);
            chk("rst_exc", s_exc, 0);
            model_reset();
        end else begin
            redirect = exec_flush | ertn_flush | br_taken_exe | br_taken_id;
            tgt = exec_flush ? exec_pc : ertn_flush ? ertn_pc : br_taken_exe ? br_target_exe : br_target_id;
            outs = m_pend.size();
            m_req = !m_halt && !redirect && (m_fpc[1:0] == 2'b00) && outs < MAXO
                    && (outs + m_ibuf.size()) < DEPTH;
            chk("req", s_req, m_req);
            if (m_req) chk("addr", s_addr, m_fpc);
            chk("valid", s_valid, m_ibuf.size() > 0);
            chk("valid_rf", if_valid_rf, m_ibuf.size() > 0);
            if (m_ibuf.size() > 0) begin
                chk("head_pc", s_pc, m_ibuf[0].pc);
                chk("head_inst", s_inst, m_ibuf[0].inst);
                chk("head_exc", s_exc, m_ibuf[0].exc);
            end else begin
                chk("empty_pc", s_pc, 0);
                chk("empty_inst", s_inst, 0);
                chk("empty_exc", s_exc, 0);
            end
            if (inst_sram_data_ok && slave_q.size() > 0) void'(slave_q.pop_front());
            if (s_req && inst_sram_addr_ok) slave_q.push_back(s_addr);
            dok = inst_sram_data_ok && outs > 0;
            if (redirect) begin
                if (dok) void'(m_pend.pop_front());
                m_discard = m_pend.size();
                m_ibuf.delete();
                m_fpc = tgt;
                m_halt = 0;
            end else begin
                misal = !m_halt && (m_fpc[1:0] != 2'b00) && (outs + m_ibuf.size()) < DEPTH;
                if (m_ibuf.size() > 0 && id_allowin) void'(m_ibuf.pop_front());
                if (dok) begin
                    e.pc = m_pend.pop_front();
                    if (m_discard > 0) begin
                        m_discard--;
                    end else begin
                        e.inst = inst_sram_rdata;
                        e.exc = 1'b0;
                        m_ibuf.push_back(e);
                    end
                end
                if (misal) begin
                    e.pc = m_fpc; e.inst = 32'd0; e.exc = 1'b1;
                    m_ibuf.push_back(e);
                    m_halt = 1;
                end
                if (m_req && inst_sram_addr_ok) begin
                    m_pend.push_back(m_fpc);
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        if (resetn) begin
            inst_sram_data_ok = 1'b0;
        end else begin
            case (resp_mode)
                0:       inst_sram_data_ok = 1'b0;
                1:       inst_sram_data_ok = (slave_q.size() > 0);
                default: inst_sram_data_ok = (slave_q.size() > 0) ? ($urandom_range(3) != 0)
                                                                  : ($urandom_range(19) == 0);
            endcase
        end
        inst_sram_rdata = (slave_q.size() > 0) ? ~slave_q[0] : $urandom();
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        #1;
        chk("arst_req", inst_sram_req, 0);
        chk("arst_valid", if_to_id_valid, 0);
        chk("arst_pc", if_pc, 0);
        chk("arst_inst", if_inst, 0);
        chk("arst_exc", if_exc_rf, 0);
        cycle();
        cycle();
        resetn = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int lim);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < lim);
        if (!s_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, if_to_id_valid=%b required 1", name, n, s_valid);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        int r;
        r = $urandom_range(15);
        t = RPC + 32'($urandom_range(255)) * 32'd4;
        if (r == 0) t[1:0] = 2'b10;
        if (r == 1) t[1:0] = 2'b01;
        if (r == 2) t = 32'hfffffff8;
        return t;
    endfunction

    task automatic random_redirect();
        logic [3:0] sel;
        do sel = 4'($urandom()); while (sel == 4'd0);
        exec_flush = sel[0]; ertn_flush = sel[1]; br_taken_exe = sel[2]; br_taken_id = sel[3];
        exec_pc = rand_target(); ertn_pc = rand_target();
        br_target_exe = rand_target(); br_target_id = rand_target();
    endtask

    initial begin
        int reqs;
        model_reset();

        // 1: single-cycle responder streams one instruction per cycle
        resp_mode = 1; inst_sram_addr_ok = 1; id_allowin = 1;
        do_reset();
        chk("const_wr", inst_sram_wr, 0);
        chk("const_size", inst_sram_size, 2'b10);
        chk("const_wstrb", inst_sram_wstrb, 0);
        chk("const_wdata", inst_sram_wdata, 0);
        wait_valid("t1_wait", 20);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cycle();
            chk("t1_valid", s_valid, 1);
            chk("t1_pc", s_pc, RPC + 32'(4 * k));
            chk("t1_inst", s_inst, ~(RPC + 32'(4 * k)));
        end

        // 2: stalled ID fills exactly DEPTH entries, then drains in order
        id_allowin = 0;
        do_reset();
        repeat (8) cycle();
        chk("t2_req_off", s_req, 0);
        chk("t2_head", s_pc, RPC);
        inst_sram_addr_ok = 0; id_allowin = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t2_pc", s_pc, RPC + 32'(4 * k));
        end
        cycle();
        chk("t2_empty", s_valid, 0);

        // 3: branch with two in flight drops both stale responses
        inst_sram_addr_ok = 1; resp_mode = 0;
        do_reset();
        repeat (3) cycle();
        chk("t3_stall", s_req, 0);
        br_taken_exe = 1; br_target_exe = 32'h1c000100; resp_mode = 1;
        cycle();
        clear_redirects();
        wait_valid("t3_wait", 20);
        chk("t3_pc", s_pc, 32'h1c000100);
        chk("t3_inst", s_inst, ~32'h1c000100);

        // 4: exception outranks a same-cycle ID branch
        repeat (3) cycle();
        exec_flush = 1; exec_pc = 32'h1c001000; br_taken_id = 1; br_target_id = 32'h1c000200;
        cycle();
        clear_redirects();
        cycle();
        chk("t4_req", s_req, 1);
        chk("t4_addr", s_addr, 32'h1c001000);
        wait_valid("t4_wait", 20);
        chk("t4_pc", s_pc, 32'h1c001000);

        // 5: misaligned target yields one ADEF entry and halts fetch
        br_taken_id = 1; br_target_id = 32'h1c000102;
        cycle();
        clear_redirects();
        wait_valid("t5_wait", 20);
        chk("t5_pc", s_pc, 32'h1c000102);
        chk("t5_exc", s_exc, 1);
        chk("t5_inst", s_inst, 0);
        reqs = 0;
        repeat (10) begin
            cycle();
            if (s_req) reqs++;
        end
        chk("t5_req_held", reqs, 0);

        // 6: reset in the middle of a live stream
        br_taken_exe = 1; br_target_exe = RPC + 32'h40;
        cycle();
        clear_redirects();
        repeat (6) cycle();
        do_reset();
        wait_valid("t6_wait", 20);
        chk("t6_pc", s_pc, RPC);
        chk("t6_inst", s_inst, ~RPC);

        // Randomized traffic, redirects and resets checked against the model every cycle
        resp_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            inst_sram_addr_ok = ($urandom_range(3) != 0);
            id_allowin = ($urandom_range(3) != 0);
            clear_redirects();
            if ($urandom_range(m_halt ? 4 : 30) == 0) random_redirect();
            if ($urandom_range(499) == 0) do_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
